des_round_ctrl: RTL and testbench

//  Iterative DES round sequencer. Accepts one 64-bit block (already initial-permuted, L0||R0),

---
 rtl/des_round_if.sv | 29 ++
 rtl/des_round_ctrl.sv | 135 +++++++++++++
 tb/tb_des_round_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_round_if.sv
// DES round controller bus: block request/response plus f-function and subkey-store links.
interface des_round_if;
    logic        start_valid;
    logic        start_ready;
    logic        decrypt;
    logic [63:0] din;
    logic [3:0]  key_idx;
    logic [47:0] subkey;
    logic [31:0] f_rdata;
    logic [47:0] f_key;
    logic [31:0] f_result;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic [3:0]  round;

    // Controller side
    modport slave (
        input  start_valid, decrypt, din, subkey, f_result, dout_ready,
        output start_ready, key_idx, f_rdata, f_key, dout, dout_valid, busy, round
    );

    // Environment side: IP/FP wrapper, f-function and key store
    modport master (
        output start_valid, decrypt, din, subkey, f_result, dout_ready,
        input  start_ready, key_idx, f_rdata, f_key, dout, dout_valid, busy, round
    );
endinterface

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: runs ROUNDS Feistel rounds on one block through a shared
// pipelined f-function, returning {R16, L16} ahead of the final permutation.
module des_round_ctrl #(
    parameter int unsigned F_LATENCY = 2,
    parameter int unsigned ROUNDS    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    des_round_if.slave  bus
);

    localparam int unsigned W_HALF = 32;
    localparam int unsigned W_BLK  = 64;
    localparam int unsigned W_IDX  = 4;
    localparam int unsigned W_WCNT = $clog2(F_LATENCY + 1);

    localparam logic [W_IDX-1:0]  LAST_RND  = W_IDX'(ROUNDS - 1);
    localparam logic [W_WCNT-1:0] LAST_WAIT = W_WCNT'(F_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [W_HALF-1:0]   l_q, l_nxt;
    logic [W_HALF-1:0]   r_q, r_nxt;
    logic [W_IDX-1:0]    rnd, rnd_nxt;
    logic [W_WCNT-1:0]   wcnt, wcnt_nxt;
    logic                dec_q, dec_nxt;
    logic [W_IDX-1:0]    key_idx_q, key_idx_nxt;
    logic [W_BLK-1:0]    dout_q, dout_nxt;
    logic                dout_valid_q, dout_valid_nxt;
    logic                start_ready_q, start_ready_nxt;
    logic                busy_q, busy_nxt;

    // Next-state, datapath and output decode
    always_comb begin
        state_nxt      = state;
        l_nxt          = l_q;
        r_nxt          = r_q;
        rnd_nxt        = rnd;
        wcnt_nxt       = wcnt;
        dec_nxt        = dec_q;
        dout_nxt       = dout_q;
        dout_valid_nxt = dout_valid_q;

        case (state)
            IDLE: begin
                if (bus.start_valid) begin
                    l_nxt     = bus.din[63:32];
                    r_nxt     = bus.din[31:0];
                    dec_nxt   = bus.decrypt;
                    rnd_nxt   = '0;
                    wcnt_nxt  = '0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                wcnt_nxt = wcnt + W_WCNT'(1);
                if (wcnt == LAST_WAIT) begin
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                l_nxt = r_q;
                r_nxt = l_q ^ bus.f_result;
                if (rnd == LAST_RND) begin
                    // Final swap folded in: output is {R16, L16}
                    dout_nxt       = {l_q ^ bus.f_result, r_q};
                    dout_valid_nxt = 1'b1;
                    state_nxt      = DONE;
                end else begin
                    rnd_nxt   = rnd + W_IDX'(1);
                    wcnt_nxt  = '0;
                    state_nxt = WAIT;
                end
            end
            DONE: begin
                if (bus.dout_ready) begin
                    dout_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        key_idx_nxt     = dec_nxt ? (LAST_RND - rnd_nxt) : rnd_nxt;
        start_ready_nxt = (state_nxt == IDLE);
        busy_nxt        = (state_nxt != IDLE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            l_q           <= '0;
            r_q           <= '0;
            rnd           <= '0;
            wcnt          <= '0;
            dec_q         <= 1'b0;
            key_idx_q     <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state         <= state_nxt;
            l_q           <= l_nxt;
            r_q           <= r_nxt;
            rnd           <= rnd_nxt;
            wcnt          <= wcnt_nxt;
            dec_q         <= dec_nxt;
            key_idx_q     <= key_idx_nxt;
            dout_q        <= dout_nxt;
            dout_valid_q  <= dout_valid_nxt;
            start_ready_q <= start_ready_nxt;
            busy_q        <= busy_nxt;
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.busy        = busy_q;
    assign bus.round       = rnd;
    assign bus.key_idx     = key_idx_q;
    assign bus.f_rdata     = r_q;
    assign bus.f_key       = bus.subkey;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: DES reference model (IP/FP, f-function, key schedule) around
// two controllers (F_LATENCY 2 and 3) with a scoreboard of expected ciphertexts.
module tb_des_round_ctrl;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SBOX [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    logic clk;
    logic rst_n;
    logic sel;
    logic start_valid;
    logic decrypt;
    logic [63:0] din;
    logic dout_ready;

    des_round_if if2 ();
    des_round_if if3 ();

    des_round_ctrl #(.F_LATENCY(2), .ROUNDS(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    des_round_ctrl #(.F_LATENCY(3), .ROUNDS(16)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    logic [47:0] ks [16];
    logic [31:0] f2_q [2];
    logic [31:0] f3_q [3];

    typedef struct {
        logic [63:0] exp_out;
        int          exp_lat;
    } sb_t;
    sb_t sb [$];

    int n_checks;
    int n_errors;

    logic [63:0] o_dout;
    logic        o_dv, o_sr, o_busy;
    logic [3:0]  o_round, o_kidx;
    logic [47:0] o_fkey;
    logic [31:0] o_frdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int tval(input int which, input int j);
        case (which)
            0:       return IP_T[j];
            1:       return FP_T[j];
            2:       return E_T[j];
            3:       return P_T[j];
            4:       return PC1_T[j];
            default: return PC2_T[j];
        endcase
    endfunction

    // DES bit t (1-based, MSB first) of an n-bit value is x[n-t]
    function automatic logic [63:0] perm(input logic [63:0] x, input int n, input int m, input int which);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < m; j++) r[m-1-j] = x[n - tval(which, j)];
        return r;
    endfunction

    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [63:0] e;
        logic [47:0] x;
        logic [5:0]  six;
        logic [31:0] so;
        logic [63:0] p;
        int          idx;
        e  = perm({32'h0, r}, 32, 48, 2);
        x  = e[47:0] ^ k;
        so = '0;
        for (int i = 0; i < 8; i++) begin
            six = x[47-6*i -: 6];
            idx = i*64 + int'({six[5], six[0]})*16 + int'(six[4:1]);
            so[31-4*i -: 4] = 4'(SBOX[idx]);
        end
        p = perm({32'h0, so}, 32, 32, 3);
        return p[31:0];
    endfunction

    // Key store returns the addressed subkey in the same cycle
    assign if2.subkey = ks[if2.key_idx];
    assign if3.subkey = ks[if3.key_idx];

    // Pipelined f-function models, F_LATENCY registers deep
    always @(posedge clk) begin
        f2_q[0] <= f_func(if2.f_rdata, if2.f_key);
        f2_q[1] <= f2_q[0];
        f3_q[0] <= f_func(if3.f_rdata, if3.f_key);
        f3_q[1] <= f3_q[0];
        f3_q[2] <= f3_q[1];
    end
    assign if2.f_result = f2_q[1];
    assign if3.f_result = f3_q[2];

    assign if2.start_valid = start_valid & ~sel;
    assign if3.start_valid = start_valid & sel;
    assign if2.decrypt     = decrypt;
    assign if3.decrypt     = decrypt;
    assign if2.din         = din;
    assign if3.din         = din;
    assign if2.dout_ready  = dout_ready;
    assign if3.dout_ready  = dout_ready;

    assign o_dout   = sel ? if3.dout        : if2.dout;
    assign o_dv     = sel ? if3.dout_valid  : if2.dout_valid;
    assign o_sr     = sel ? if3.start_ready : if2.start_ready;
    assign o_busy   = sel ? if3.busy        : if2.busy;
    assign o_round  = sel ? if3.round       : if2.round;
    assign o_kidx   = sel ? if3.key_idx     : if2.key_idx;
    assign o_fkey   = sel ? if3.f_key       : if2.f_key;
    assign o_frdata = sel ? if3.f_rdata     : if2.f_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One block through the selected controller; expected result queued at accept
    task automatic run_block(input string tag, input logic [63:0] blk, input logic dec,
                             input logic [63:0] exp_out, input int lat, input int hold,
                             input bit glitch);
        int          k;
        int          bound;
        int          exp_r;
        int          kexp;
        bit          pulsed;
        logic [63:0] held;
        logic [63:0] res;
        sb_t         e;
        bound = 0;
        while (!o_sr && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        check({tag, "_ready"}, 64'(o_sr), 64'(1'b1));
        din         = perm(blk, 64, 64, 0);
        decrypt     = dec;
        start_valid = 1'b1;
        e.exp_out   = exp_out;
        e.exp_lat   = 16 * (lat + 1);
        sb.push_back(e);
        @(negedge clk);
        start_valid = 1'b0;
        din         = {$urandom, $urandom};
        decrypt     = ~dec;
        k           = 0;
        pulsed      = 1'b0;
        check({tag, "_busy"}, 64'({o_busy, o_sr}), 64'(2'b10));
        while (!o_dv && k <= e.exp_lat + 20) begin
            exp_r = k / (lat + 1);
            if (exp_r > 15) exp_r = 15;
            kexp  = dec ? 15 - exp_r : exp_r;
            check({tag, "_round"}, 64'(o_round), 64'(exp_r));
            check({tag, "_kidx"}, 64'(o_kidx), 64'(kexp));
            check({tag, "_fkey"}, 64'(o_fkey), 64'(ks[kexp]));
            if (glitch && exp_r == 3 && !pulsed) begin
                start_valid = 1'b1;
                din         = '1;
                pulsed      = 1'b1;
            end else begin
                start_valid = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start_valid = 1'b0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            e   = sb.pop_front();
            res = perm(o_dout, 64, 64, 1);
            check({tag, "_latency"}, 64'(k), 64'(e.exp_lat));
            check({tag, "_dout"}, res, e.exp_out);
        end
        held = o_dout;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_dout"}, o_dout, held);
            check({tag, "_hold_flags"}, 64'({o_dv, o_sr}), 64'(2'b10));
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        check({tag, "_release"}, 64'({o_sr, o_dv, o_busy}), 64'(3'b100));
    endtask

    initial begin
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] pk;
        int          bound;
        int          dv_seen;

        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        sel         = 1'b0;
        start_valid = 1'b0;
        decrypt     = 1'b0;
        din         = '0;
        dout_ready  = 1'b0;

        pk = perm(KEY, 64, 56, 4);
        cd = pk[55:0];
        c  = cd[55:28];
        d  = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < SHIFTS[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            pk    = perm({8'h0, c, d}, 56, 48, 5);
            ks[i] = pk[47:0];
        end

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_start_ready", 64'(o_sr), 64'(1'b1));
        check("rst_busy", 64'(o_busy), 64'(1'b0));
        check("rst_dout_valid", 64'(o_dv), 64'(1'b0));
        check("rst_dout", o_dout, 64'h0);
        check("rst_round", 64'(o_round), 64'(0));
        sel = 1'b1;
        #1;
        check("rst_lat3_ready", 64'({o_sr, o_busy, o_dv}), 64'(3'b100));
        sel = 1'b0;
        #1;

        run_block("enc", PT, 1'b0, CT, 2, 0, 1'b0);
        run_block("dec", CT, 1'b1, PT, 2, 0, 1'b0);
        run_block("hold", PT, 1'b0, CT, 2, 10, 1'b0);

        // Reset during round 7 aborts the block
        @(negedge clk);
        din         = perm(PT, 64, 64, 0);
        decrypt     = 1'b0;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        bound       = 0;
        while (o_round != 4'd7 && bound < 60) begin
            @(negedge clk);
            bound++;
        end
        check("abort_reach_r7", 64'(o_round), 64'(7));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_flags", 64'({o_sr, o_busy, o_dv}), 64'(3'b100));
        check("abort_dout", o_dout, 64'h0);
        check("abort_round_kidx", 64'({o_round, o_kidx}), 64'(0));
        check("abort_f_rdata", 64'(o_frdata), 64'(0));
        dv_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_dv) dv_seen++;
        end
        check("abort_no_dout_valid", 64'(dv_seen), 64'(0));
        run_block("enc_after_rst", PT, 1'b0, CT, 2, 0, 1'b0);

        // Start pulse while busy is ignored
        run_block("busy_start", PT, 1'b0, CT, 2, 0, 1'b1);

        // Deeper f-function pipeline
        sel = 1'b1;
        #1;
        run_block("lat3_enc", PT, 1'b0, CT, 3, 2, 1'b0);
        run_block("lat3_dec", CT, 1'b1, PT, 3, 0, 1'b0);
        sel = 1'b0;

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
